// File: rtl/glb_arbiter.sv
// Round-robin arbiter sharing the single GLB port between the DMA and PE-side requesters.
// Optional GLB_ARB_DMA_PRIO_EN gives requester 0 (tiling DMA) fixed priority over the rest.
module glb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH*4-1:0] req_w_data,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH*4-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]           glb_r_addr,
    input  logic [DATA_WIDTH*4-1:0]         glb_r_data,
    output logic                            glb_we,
    output logic [ADDR_WIDTH-1:0]           glb_w_addr,
    output logic [DATA_WIDTH*4-1:0]         glb_w_data,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

    localparam int unsigned WORD_W = DATA_WIDTH * 4;
    localparam int unsigned ID_W   = $clog2(NUM_REQ);

    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       ptr_nxt_c;
    logic                  found_c;
    logic                  accept_c;
    logic [ID_W-1:0]       gnt_idx_c;
    logic [ID_W-1:0]       cand_c;
    logic                  gnt_we_c;
    logic [ADDR_WIDTH-1:0] gnt_addr_c;
    logic [WORD_W-1:0]     gnt_data_c;

    logic                  tag1_v;
    logic [ID_W-1:0]       tag1_id;
    logic                  tag2_v;
    logic [ID_W-1:0]       tag2_id;

    // Rotating search from ptr; first valid requester wins
    always_comb begin
        found_c   = 1'b0;
        gnt_idx_c = '0;
        cand_c    = '0;
`ifdef GLB_ARB_DMA_PRIO_EN
        if (req_valid[0]) begin
            found_c   = 1'b1;
            gnt_idx_c = '0;
        end
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found_c && req_valid[cand_c]) begin
                found_c   = 1'b1;
                gnt_idx_c = cand_c;
            end
        end
    end

    assign accept_c   = found_c & rst;
    assign req_ready  = accept_c ? (NUM_REQ'(1) << gnt_idx_c) : '0;
    assign gnt_we_c   = req_we[gnt_idx_c];
    assign gnt_addr_c = req_addr[gnt_idx_c*ADDR_WIDTH +: ADDR_WIDTH];
    assign gnt_data_c = req_w_data[gnt_idx_c*WORD_W +: WORD_W];

    // Pointer moves past the winner; DMA priority grants leave it alone
    always_comb begin
        ptr_nxt_c = ptr;
`ifdef GLB_ARB_DMA_PRIO_EN
        if (accept_c && (gnt_idx_c != '0)) begin
            ptr_nxt_c = ID_W'((32'(gnt_idx_c) + 32'd1) % NUM_REQ);
        end
`else
        if (accept_c) begin
            ptr_nxt_c = ID_W'((32'(gnt_idx_c) + 32'd1) % NUM_REQ);
        end
`endif
    end

    // Command issue: one registered GLB command per accepted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            grant_id   <= '0;
            glb_we     <= 1'b0;
            glb_w_addr <= '0;
            glb_w_data <= '0;
            glb_r_addr <= '0;
        end else begin
            ptr    <= ptr_nxt_c;
            glb_we <= accept_c & gnt_we_c;
            if (accept_c) begin
                grant_id <= gnt_idx_c;
                if (gnt_we_c) begin
                    glb_w_addr <= gnt_addr_c;
                    glb_w_data <= gnt_data_c;
                end else begin
                    glb_r_addr <= gnt_addr_c;
                end
            end
        end
    end

    // Read tag pipeline: stage 1 aligns with glb_r_addr, stage 2 with glb_r_data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag1_v    <= 1'b0;
            tag1_id   <= '0;
            tag2_v    <= 1'b0;
            tag2_id   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            tag1_v    <= accept_c & ~gnt_we_c;
            tag1_id   <= gnt_idx_c;
            tag2_v    <= tag1_v;
            tag2_id   <= tag1_id;
            rsp_valid <= tag2_v ? (NUM_REQ'(1) << tag2_id) : '0;
            if (tag2_v) begin
                rsp_data <= glb_r_data;
            end
        end
    end

endmodule

// File: tb/tb_glb_arbiter.sv
// Self-checking bench for glb_arbiter: arbitration table, directed corner sequences and a
// response/command scoreboard checked against a reference memory.
module tb_glb_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_we;
    logic [127:0] req_addr;
    logic [127:0] req_w_data;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic [31:0]  glb_r_addr;
    logic [31:0]  glb_r_data;
    logic         glb_we;
    logic [31:0]  glb_w_addr;
    logic [31:0]  glb_w_data;
    logic [1:0]   grant_id;

    logic [31:0]  drv_addr  [4];
    logic [31:0]  drv_wdata [4];

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned due;
        logic [1:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;

    exp_t rq[$];
    exp_t wq[$];
    exp_t mon_e;
    logic [1:0]  exp_gid = 2'd0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] glb_mem [256];
    logic [3:0]  one4 = 4'b0001;
    vec_t        tbl[$];

    glb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .NUM_REQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_w_data(req_w_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
        .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]   = drv_addr[i];
            req_w_data[i*32 +: 32] = drv_wdata[i];
        end
    end

    // Synchronous GLB model: one-cycle read latency, write committed at the clock edge
    initial for (int i = 0; i < 256; i++) glb_mem[i] = init_val(32'(i * 4));
    always @(posedge clk) begin
        if (glb_we) glb_mem[glb_w_addr[9:2]] <= glb_w_data;
        glb_r_data <= glb_mem[glb_r_addr[9:2]];
    end

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            rq.delete();
            wq.delete();
            exp_gid = 2'd0;
            check("rst_ready", req_ready, 0);
            check("rst_glb_we", glb_we, 0);
            check("rst_rsp_valid", rsp_valid, 0);
        end else begin
            check("grant_id", grant_id, exp_gid);
            if (wq.size() > 0 && wq[0].due == cyc) begin
                mon_e = wq.pop_front();
                check("sb_glb_we", glb_we, 1);
                check("sb_w_addr", glb_w_addr, mon_e.addr);
                check("sb_w_data", glb_w_data, mon_e.data);
            end else begin
                check("sb_glb_we_idle", glb_we, 0);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mon_e = rq.pop_front();
                check("sb_rsp_valid", rsp_valid, one4 << mon_e.id);
                check("sb_rsp_data", rsp_data, mon_e.data);
            end else begin
                check("sb_rsp_idle", rsp_valid, 0);
            end
            check("ready_subset", req_ready & ~req_valid, 0);
            check("ready_onehot", ($countones(req_ready) <= 1), 1);
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_gid = 2'(i);
                    if (req_we[i]) begin
                        ref_mem[drv_addr[i]] = drv_wdata[i];
                        wq.push_back('{cyc + 1, 2'(i), drv_addr[i], drv_wdata[i]});
                    end else begin
                        rq.push_back('{cyc + 3, 2'(i), drv_addr[i], ref_read(drv_addr[i])});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_glb_we"}, glb_we, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_r_addr"}, glb_r_addr, 0);
        check({tag, "_w_addr"}, glb_w_addr, 0);
        check({tag, "_w_data"}, glb_w_data, 0);
        check({tag, "_grant_id"}, grant_id, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef GLB_ARB_DMA_PRIO_EN
        for (int k = 0; k < 8; k++) tbl.push_back('{4'b1111, 4'b0001});
        tbl.push_back('{4'b1110, 4'b0010});
        tbl.push_back('{4'b1100, 4'b0100});
        tbl.push_back('{4'b1000, 4'b1000});
        tbl.push_back('{4'b0001, 4'b0001});
        tbl.push_back('{4'b0011, 4'b0001});
        tbl.push_back('{4'b0010, 4'b0010});
        tbl.push_back('{4'b1001, 4'b0001});
        tbl.push_back('{4'b1000, 4'b1000});
`else
        for (int k = 0; k < 8; k++) tbl.push_back('{4'b1111, one4 << (k % 4)});
        tbl.push_back('{4'b0000, 4'b0000});
        tbl.push_back('{4'b0110, 4'b0010});
        tbl.push_back('{4'b0100, 4'b0100});
        tbl.push_back('{4'b1001, 4'b1000});
        tbl.push_back('{4'b0001, 4'b0001});
        tbl.push_back('{4'b0001, 4'b0001});
        tbl.push_back('{4'b0101, 4'b0100});
        tbl.push_back('{4'b0011, 4'b0001});
        tbl.push_back('{4'b0010, 4'b0010});
        tbl.push_back('{4'b1000, 4'b1000});
`endif
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_we    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            drv_addr[i]  = 32'h100 + 32'(i * 16);
            drv_wdata[i] = 32'h0;
        end

        // Reset held with every requester asking
        repeat (3) tick();
        mid();
        check_reset_outputs("reset_hold");
        tick();
        rst = 1'b1;

        // Arbitration table, all reads
        foreach (tbl[k]) begin
            req_valid = tbl[k].valid;
            mid();
            check($sformatf("arb_ready[%0d]", k), req_ready, tbl[k].exp_ready);
            tick();
        end
        req_valid = 4'b0000;
        repeat (4) tick();

        // Single write from requester 2
        req_valid = 4'b0100; req_we = 4'b0100;
        drv_addr[2] = 32'h40; drv_wdata[2] = 32'hDEAD_BEEF;
        mid();
        check("wr_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000; req_we = 4'b0000;
        mid();
        check("wr_glb_we", glb_we, 1);
        check("wr_w_addr", glb_w_addr, 32'h40);
        check("wr_w_data", glb_w_data, 32'hDEAD_BEEF);
        tick();
        mid();
        check("wr_glb_we_drop", glb_we, 0);
        tick();

        // Read latency from requester 1
        req_valid = 4'b0010; drv_addr[1] = 32'h10;
        mid();
        check("rd_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        mid(); check("rd_t1_quiet", rsp_valid, 0); tick();
        mid(); check("rd_t2_quiet", rsp_valid, 0); tick();
        mid();
        check("rd_t3_valid", rsp_valid, 4'b0010);
        check("rd_t3_data", rsp_data, 32'h1234_5678);
        tick();
        mid(); check("rd_t4_drop", rsp_valid, 0); tick();

        // Write then read of the same address on the next cycle
        req_valid = 4'b0001; req_we = 4'b0001;
        drv_addr[0] = 32'h80; drv_wdata[0] = 32'hA5A5_A5A5;
        mid(); check("raw_wr_ready", req_ready, 4'b0001); tick();
        req_valid = 4'b1000; req_we = 4'b0000; drv_addr[3] = 32'h80;
        mid(); check("raw_rd_ready", req_ready, 4'b1000); tick();
        req_valid = 4'b0000;
        tick();
        tick();
        mid();
        check("raw_rsp_valid", rsp_valid, 4'b1000);
        check("raw_rsp_data", rsp_data, 32'hA5A5_A5A5);
        tick();

        // Lone requester streaming reads every cycle
        req_valid = 4'b0010; drv_addr[1] = 32'h110;
        for (int k = 0; k < 5; k++) begin
            mid();
            check($sformatf("stream_ready[%0d]", k), req_ready, 4'b0010);
            tick();
        end
        req_valid = 4'b0000;
        repeat (4) tick();

        // Reset one cycle after a read handshake
        req_valid = 4'b0100; drv_addr[2] = 32'h40;
        mid(); check("mid_rst_ready", req_ready, 4'b0100); tick();
        req_valid = 4'b0000;
        rst = 1'b0;
        mid(); check("mid_rst_rsp", rsp_valid, 0); tick();
        rst = 1'b1;
        mid();
        check_reset_outputs("post_reset");
        tick();
        for (int k = 0; k < 4; k++) begin
            mid();
            check($sformatf("post_reset_quiet[%0d]", k), rsp_valid, 0);
            tick();
        end
        req_valid = 4'b1010;
        mid(); check("post_reset_first_grant", req_ready, 4'b0010); tick();
        req_valid = 4'b0000;
        repeat (5) tick();

        mid();
        check("sb_drained", rq.size() + wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_arbiter.md
# glb_arbiter

Round-robin arbiter that shares the single Global Buffer (GLB) access port between the tiling DMA engine and the PE-array-side readers/writers (ifmap, filter/bias, opsum). It accepts one request per cycle via valid/ready, issues it to the GLB as a registered command, and routes synchronous-SRAM read data back to the issuing requester with a tagged response pulse. It sits between the controller-side requesters and the GLB macro.

## Interface
- ADDR_WIDTH, 32, GLB byte-address width
- DATA_WIDTH, 8, element width; GLB word is DATA_WIDTH*4 bits
- NUM_REQ, 4, number of requesters (index 0 = tiling DMA, 1 = ifmap, 2 = filter/bias, 3 = opsum)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed byte addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_w_data  in  NUM_REQ*DATA_WIDTH*4  packed write data
- rsp_valid  out  NUM_REQ  one-cycle read-response pulse to requester i
- rsp_data  out  DATA_WIDTH*4  read data, shared, qualified by rsp_valid
- glb_r_addr  out  ADDR_WIDTH  GLB read address
- glb_r_data  in  DATA_WIDTH*4  GLB read data, valid one cycle after glb_r_addr
- glb_we  out  1  GLB write enable
- glb_w_addr  out  ADDR_WIDTH  GLB write address
- glb_w_data  out  DATA_WIDTH*4  GLB write data
- grant_id  out  $clog2(NUM_REQ)  index of last accepted requester (debug)

## Operation
- Handshake: transfer when req_valid[i] && req_ready[i]. Requester holds valid, we, addr, w_data stable until accepted; valid never drops before accept.
- req_ready combinational from req_valid and round-robin pointer `ptr`; at most one bit set; req_ready[i] never high without req_valid[i]; all zero while rst low.
- Round-robin: search starts at ptr, wraps at NUM_REQ-1 -> 0; first valid wins. After accepting i, ptr <= (i+1) mod NUM_REQ. No accept -> ptr unchanged.
- Accepted write (cycle T): at T+1 glb_we=1, glb_w_addr/glb_w_data = payload. No accept -> glb_we=0; address/data hold last value.
- Accepted read (cycle T): at T+1 glb_r_addr = addr; tag {valid,id} enters 2-stage pipeline; at T+3 rsp_valid[id]=1 for one cycle, rsp_data = glb_r_data registered at the end of T+2.
- Ordering: commands reach GLB in acceptance order; write at T then read of same address at T+1 returns new data (GLB write-before-read ordering by issue cycle).
- Back-to-back: one accept per cycle sustained; reads pipelined, up to 3 in flight.
- Address/width: addresses passed unmodified (no alignment check); glb_we only on write accepts.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_data 0, glb_we 0, glb_r_addr 0, glb_w_addr 0, glb_w_data 0, grant_id 0, ptr 0, tag pipeline empty.
- Latency: write handshake->glb_we 1 cycle; read handshake->rsp_valid 3 cycles.
- Reset mid-operation: in-flight reads discarded, no rsp_valid after release; first post-reset grant searches from 0.
- All requesters valid: grants rotate 0,1,2,3,0... one per cycle.
- Single requester valid continuously: granted every cycle.
- rsp_valid and a new grant to the same requester may coincide; independent.

## Configuration
- GLB_ARB_DMA_PRIO_EN defined: requester 0 (tiling DMA) wins whenever req_valid[0]=1, regardless of ptr, and ptr does not advance on its grants; others arbitrate round-robin among themselves.
- Undefined: pure round-robin over all NUM_REQ requesters, requester 0 included.

## Test plan
- Reset: hold rst low with all req_valid=1 -> req_ready=0, glb_we=0, all outputs 0; release -> requester 0 granted first cycle.
- Single write: req 2 writes addr 0x40, data 0xDEADBEEF -> req_ready[2] same cycle, next cycle glb_we=1, glb_w_addr=0x40, glb_w_data=0xDEADBEEF, then glb_we=0.
- Read latency: req 1 reads 0x10, GLB model returns 0x12345678 -> rsp_valid=4'b0010 exactly 3 cycles after handshake, rsp_data=0x12345678.
- Fairness: all four valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3 (macro undefined); with GLB_ARB_DMA_PRIO_EN, req 0 granted all 8 cycles.
- RAW ordering: req 0 writes 0x80=0xA5A5A5A5, req 3 reads 0x80 next cycle -> rsp_valid[3] with 0xA5A5A5A5.
- Reset mid-read: assert rst 1 cycle after read handshake -> no rsp_valid after release; outputs at reset values.
